// File: rtl/data_mem_ctrl.sv
// Word-organised data RAM controller: byte-address decode, per-byte write enables,
// registered read with valid strobe, alignment/range errors, post-reset clear engine.
module data_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int INIT_CLEAR = 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [ADDR_WIDTH-1:0]   Data_address,
    input  logic [DATA_WIDTH-1:0]   Data_in,
    input  logic [DATA_WIDTH/8-1:0] Byte_en,
    input  logic                    we,
    input  logic                    re,
    output logic [DATA_WIDTH-1:0]   Data_out,
    output logic                    Data_valid,
    output logic                    Addr_err,
    output logic                    Busy
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [CNT_W-1:0]        mem_idx;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    addr_bad;
    logic                    accept;

    // Range check runs on the full-width index so large addresses never alias.
    assign word_idx     = Data_address >> OFF_W;
    assign mem_idx      = word_idx[CNT_W-1:0];
    assign out_of_range = word_idx >= ADDR_WIDTH'(DEPTH);
    assign addr_bad     = misaligned | out_of_range;
    assign accept       = (state == READY) && !Busy && !Reset;

    generate
        if (OFF_W == 0) begin : g_no_off
            assign misaligned = 1'b0;
        end else begin : g_off
            assign misaligned = |Data_address[OFF_W-1:0];
        end
    endgenerate

    logic                    wr_en;
    logic [CNT_W-1:0]        wr_idx;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [NB-1:0]           wr_lanes;

    // Single write port shared by the clear engine and CPU stores.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = mem_idx;
        wr_data  = Data_in;
        wr_lanes = Byte_en;
        if (!Reset && state == CLEAR) begin
            wr_en    = 1'b1;
            wr_idx   = cnt;
            wr_data  = '0;
            wr_lanes = '1;
        end else if (accept && we && !addr_bad) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_lanes[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= (INIT_CLEAR != 0) ? CLEAR : READY;
            cnt        <= '0;
            Busy       <= 1'b1;
            Data_out   <= '0;
            Data_valid <= 1'b0;
            Addr_err   <= 1'b0;
        end else begin
            Data_valid <= 1'b0;
            Addr_err   <= 1'b0;
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DEPTH - 1)) begin
                        state <= READY;
                        Busy  <= 1'b0;
                    end
                end
                READY: begin
                    Busy <= 1'b0;
                    if (accept) begin
                        if ((we || re) && addr_bad) Addr_err <= 1'b1;
                        // Read-first: nonblocking semantics return pre-write contents.
                        if (re) begin
                            Data_valid <= 1'b1;
                            Data_out   <= addr_bad ? '0 : mem[mem_idx];
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (32-bit words, 256 deep, clear after reset).
module tb_data_mem_ctrl;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Data_address;
    logic [31:0] Data_in;
    logic [3:0]  Byte_en;
    logic        we;
    logic        re;
    logic [31:0] Data_out;
    logic        Data_valid;
    logic        Addr_err;
    logic        Busy;

    int total = 0;
    int bad   = 0;

    data_mem_ctrl #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32), .INIT_CLEAR(1)) dut (
        .Clk(Clk), .Reset(Reset), .Data_address(Data_address), .Data_in(Data_in),
        .Byte_en(Byte_en), .we(we), .re(re), .Data_out(Data_out),
        .Data_valid(Data_valid), .Addr_err(Addr_err), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic        vld;
        logic        err;
        logic [31:0] dout;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        we = w; re = r; Data_address = a; Data_in = d; Byte_en = b;
    endtask

    // Counts edges from reset release until Busy drops, checking no response leaks out.
    task automatic count_busy(output int n);
        n = 0;
        while (Busy && n < 400) begin
            @(posedge Clk); #1;
            n++;
            if (Data_valid !== 1'b0 || Addr_err !== 1'b0) begin
                bad++;
                $display("FAIL busy_quiet: cycle %0d valid=%b err=%b want 0 0", n, Data_valid, Addr_err);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        int n;
        Reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        vt[0]  = '{1'b0, 1'b1, 32'h000, 32'h0,        4'h0, 1'b1, 1'b0, 32'h00000000};
        vt[1]  = '{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 1'b0, 32'h00000000};
        vt[2]  = '{1'b0, 1'b1, 32'h200, 32'h0,        4'h0, 1'b1, 1'b0, 32'h00000000};
        vt[3]  = '{1'b0, 1'b1, 32'h3FC, 32'h0,        4'h0, 1'b1, 1'b0, 32'h00000000};
        vt[4]  = '{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 1'b0, 32'h00000000};
        vt[5]  = '{1'b1, 1'b0, 32'h010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h00000000};
        vt[6]  = '{1'b1, 1'b0, 32'h010, 32'h000000AA, 4'h1, 1'b0, 1'b0, 32'h00000000};
        vt[7]  = '{1'b0, 1'b1, 32'h010, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEAA};
        vt[8]  = '{1'b0, 1'b0, 32'h000, 32'h0,        4'h0, 1'b0, 1'b0, 32'hDEADBEAA};
        vt[9]  = '{1'b1, 1'b1, 32'h020, 32'h12345678, 4'hF, 1'b1, 1'b0, 32'h00000000};
        vt[10] = '{1'b0, 1'b1, 32'h020, 32'h0,        4'h0, 1'b1, 1'b0, 32'h12345678};
        vt[11] = '{1'b0, 1'b1, 32'h013, 32'h0,        4'h0, 1'b1, 1'b1, 32'h00000000};
        vt[12] = '{1'b0, 1'b1, 32'h400, 32'h0,        4'h0, 1'b1, 1'b1, 32'h00000000};
        vt[13] = '{1'b0, 1'b1, 32'h010, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEAA};
        vt[14] = '{1'b1, 1'b0, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 32'hDEADBEAA};
        vt[15] = '{1'b1, 1'b0, 32'h00010000, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 32'hDEADBEAA};
        vt[16] = '{1'b0, 1'b1, 32'h000, 32'h0,        4'h0, 1'b1, 1'b0, 32'h00000000};
        vt[17] = '{1'b1, 1'b0, 32'h010, 32'h11111111, 4'h0, 1'b0, 1'b0, 32'h00000000};
        vt[18] = '{1'b0, 1'b1, 32'h010, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEAA};

        // Reset for three cycles, then time the clear.
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        chk("rst_busy",  {31'b0, Busy},       32'd1);
        chk("rst_dout",  Data_out,            32'h0);
        chk("rst_valid", {31'b0, Data_valid}, 32'd0);
        chk("rst_err",   {31'b0, Addr_err},   32'd0);
        count_busy(n);
        chk("clear_len", n, 32'd256);

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].we, vt[i].re, vt[i].addr, vt[i].din, vt[i].be);
            @(posedge Clk); #1;
            chk($sformatf("v%0d_valid", i), {31'b0, Data_valid}, {31'b0, vt[i].vld});
            chk($sformatf("v%0d_err", i),   {31'b0, Addr_err},   {31'b0, vt[i].err});
            chk($sformatf("v%0d_dout", i),  Data_out,            vt[i].dout);
        end

        // Fill 16 words, then stream them back on consecutive cycles.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 32'(i * 4), 32'hA5000000 | 32'(i), 4'hF);
            @(posedge Clk); #1;
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 32'(i * 4), 32'h0, 4'h0);
            @(posedge Clk); #1;
            chk($sformatf("burst%0d_valid", i), {31'b0, Data_valid}, 32'd1);
            chk($sformatf("burst%0d_dout", i),  Data_out, 32'hA5000000 | 32'(i));
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge Clk); #1;
        chk("burst_end_valid", {31'b0, Data_valid}, 32'd0);

        // Reset mid-clear restarts the full clear; requests during Busy are ignored.
        drive(1'b1, 1'b0, 32'h004, 32'hCAFEF00D, 4'hF);
        @(posedge Clk); #1;
        drive(1'b0, 1'b1, 32'h004, 32'h0, 4'h0);
        @(posedge Clk); #1;
        chk("cafe_rd", Data_out, 32'hCAFEF00D);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("rst2_dout", Data_out, 32'h0);
        repeat (100) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        drive(1'b1, 1'b1, 32'h004, 32'hFFFFFFFF, 4'hF);
        count_busy(n);
        chk("reclear_len", n, 32'd256);
        drive(1'b0, 1'b1, 32'h004, 32'h0, 4'h0);
        @(posedge Clk); #1;
        chk("post_clr_004_valid", {31'b0, Data_valid}, 32'd1);
        chk("post_clr_004", Data_out, 32'h0);
        drive(1'b0, 1'b1, 32'h03C, 32'h0, 4'h0);
        @(posedge Clk); #1;
        chk("post_clr_03c", Data_out, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge Clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
